// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
// Shared types and helpers for the banked FIR MAC controller.
//   state_e    : sequencer states
//   BANK_W     : bank-select width for the default 4-bank configuration
//   DEPTH      : bank depth for the default 16-word configuration
//   calc_taps  : per-bank tap count T from a total coefficient count
package fir_ctrl_pkg;

    localparam int DEF_NUM_BANK = 4;
    localparam int DEF_ADDR_W   = 4;
    localparam int BANK_W       = $clog2(DEF_NUM_BANK);
    localparam int DEPTH        = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COEFFWR,
        S_WREND,
        S_LOOP,
        S_FLUSH,
        S_SUM,
        S_OUTPUT
    } state_e;

    // T = ceil(num_coeff / num_bank), kept inside 1..depth so a sweep
    // always reads at least one word and never runs past the bank end.
    function automatic int calc_taps(input int num_coeff, input int num_bank,
                                     input int depth);
        int t;
        t = (num_coeff + num_bank - 1) / num_bank;
        if (t < 1)     t = 1;
        if (t > depth) t = depth;
        return t;
    endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// fir_tap_counter
// Up-counter for the common coefficient read address with a loadable
// terminal value (T-1).
//   iClk12M, iRsn : clock, async active-low reset
//   load_i        : capture last_i as the terminal value
//   last_i        : terminal value T-1
//   clr_i         : return the count to 0 (priority over en_i)
//   en_i          : increment
//   cnt_o         : current count / read address
//   tc_o          : count equals terminal value
module fir_tap_counter
    import fir_ctrl_pkg::*;
#(
    parameter int W = DEF_ADDR_W
) (
    input  logic         iClk12M,
    input  logic         iRsn,
    input  logic         load_i,
    input  logic [W-1:0] last_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] last_q, last_d;

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
        if (load_i)    last_d = last_i;
    end

    // last_q resets to 0, i.e. T=1.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_q);

endmodule

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl
// Control sequencer for the banked FIR datapath: coefficient write
// routing, per-sample parallel read sweep, MAC enables, flush, bank sum
// and output strobe, with busy status and sticky overrun detection.
//   iClk12M, iRsn      : clock, async active-low reset
//   iEnSample          : new-sample strobe
//   iCoeffUpdateFlag   : coefficient write window
//   iAddrRam/iWrDtRam  : write address {word, bank} and data
//   iNumOfCoeff        : total tap count
//   iClrOvr            : clear oOverrun
//   oCsnRam/oWrnRam    : per-bank chip select (low) / write (high)
//   oAddrRam/oWrDtRam  : per-bank address / write data
//   oEnDelay..oEnSum   : datapath enables
//   oValid, oBusy      : output strobe, processing status
//   oOverrun           : sticky dropped-sample flag
//
// state     | meaning
// ----------+---------------------------------------------
// S_IDLE    | waiting for a sample or coefficient update
// S_COEFFWR | one coefficient write per cycle
// S_WREND   | update finished, waiting like IDLE
// S_LOOP    | parallel read sweep k = 0..T-1
// S_FLUSH   | drain MAC pipeline (MAC_LAT cycles)
// S_SUM     | cross-bank sum
// S_OUTPUT  | output strobe, address back to 0
module fir_mac_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int  NUM_BANK = DEF_NUM_BANK,
    parameter int  ADDR_W   = DEF_ADDR_W,
    parameter int  DATA_W   = 16,
    parameter int  MAC_LAT  = 1,
    localparam int BW       = $clog2(NUM_BANK),
    parameter int  CNT_W    = BW + ADDR_W + 1
) (
    input  logic                       iClk12M,
    input  logic                       iRsn,
    input  logic                       iEnSample,
    input  logic                       iCoeffUpdateFlag,
    input  logic [BW+ADDR_W-1:0]       iAddrRam,
    input  logic [DATA_W-1:0]          iWrDtRam,
    input  logic [CNT_W-1:0]           iNumOfCoeff,
    input  logic                       iClrOvr,
    output logic [NUM_BANK-1:0]        oCsnRam,
    output logic [NUM_BANK-1:0]        oWrnRam,
    output logic [NUM_BANK*ADDR_W-1:0] oAddrRam,
    output logic [NUM_BANK*DATA_W-1:0] oWrDtRam,
    output logic                       oEnDelay,
    output logic                       oEnMul,
    output logic                       oEnAcc,
    output logic                       oEnAdd,
    output logic                       oEnSum,
    output logic                       oValid,
    output logic                       oBusy,
    output logic                       oOverrun
);

    localparam int FL_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_e            state_q, state_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic              ovr_q, ovr_d;

    logic              tap_load, tap_clr, tap_en, tap_tc;
    logic [ADDR_W-1:0] tap_last, tap_cnt;

    logic              waiting, busy, ovr_set;
    logic [BW-1:0]     wr_bank;
    logic [ADDR_W-1:0] wr_word;

    assign wr_bank  = iAddrRam[BW-1:0];
    assign wr_word  = iAddrRam[BW +: ADDR_W];
    assign tap_last = ADDR_W'(calc_taps(int'(iNumOfCoeff), NUM_BANK, 1 << ADDR_W) - 1);

    assign waiting = (state_q == S_IDLE) || (state_q == S_WREND);
    assign busy    = (state_q == S_LOOP) || (state_q == S_FLUSH) ||
                     (state_q == S_SUM)  || (state_q == S_OUTPUT);

    fir_tap_counter #(.W(ADDR_W)) u_tap_cnt (
        .iClk12M (iClk12M),
        .iRsn    (iRsn),
        .load_i  (tap_load),
        .last_i  (tap_last),
        .clr_i   (tap_clr),
        .en_i    (tap_en),
        .cnt_o   (tap_cnt),
        .tc_o    (tap_tc)
    );

    // Next state, counter controls and overrun.
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        tap_load = 1'b0;
        tap_clr  = 1'b0;
        tap_en   = 1'b0;
        unique case (state_q)
            S_IDLE, S_WREND: begin
                if (iCoeffUpdateFlag) begin
                    state_d  = S_COEFFWR;
                    tap_load = 1'b1;
                end else if (iEnSample) begin
                    state_d = S_LOOP;
                end
            end
            S_COEFFWR: if (!iCoeffUpdateFlag) state_d = S_WREND;
            S_LOOP: begin
                // Hold at T-1 on the last tap so the address only wraps at OUTPUT.
                if (tap_tc) begin
                    state_d = S_FLUSH;
                    flush_d = FL_W'(MAC_LAT - 1);
                end else begin
                    tap_en = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_q == '0) state_d = S_SUM;
                else               flush_d = flush_q - 1'b1;
            end
            S_SUM: state_d = S_OUTPUT;
            S_OUTPUT: begin
                state_d = S_IDLE;
                tap_clr = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        ovr_set = iEnSample && (busy || (waiting && iCoeffUpdateFlag));
        if (ovr_set)      ovr_d = 1'b1;
        else if (iClrOvr) ovr_d = 1'b0;
        else              ovr_d = ovr_q;
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            flush_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            ovr_q   <= ovr_d;
        end
    end

    // Outputs: state-decoded, except the write path passes inputs through
    // and oEnDelay follows the accepted strobe.
    always_comb begin
        oCsnRam  = '1;
        oWrnRam  = '0;
        oWrDtRam = '0;
        for (int b = 0; b < NUM_BANK; b++) oAddrRam[b*ADDR_W +: ADDR_W] = tap_cnt;
        oEnDelay = waiting && !iCoeffUpdateFlag && iEnSample;
        oEnMul   = (state_q == S_LOOP) || (state_q == S_FLUSH);
        oEnAcc   = oEnMul;
        oEnAdd   = (state_q == S_LOOP) && (tap_cnt == '0);
        oEnSum   = (state_q == S_SUM);
        oValid   = (state_q == S_OUTPUT);
        oBusy    = busy;
        oOverrun = ovr_q;
        if (state_q == S_COEFFWR) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (wr_bank == BW'(b)) begin
                    oCsnRam[b]                   = 1'b0;
                    oWrnRam[b]                   = 1'b1;
                    oAddrRam[b*ADDR_W +: ADDR_W] = wr_word;
                    oWrDtRam[b*DATA_W +: DATA_W] = iWrDtRam;
                end
            end
        end else if (state_q == S_LOOP) begin
            oCsnRam = '0;
        end
    end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
module tb_fir_mac_ctrl;

    localparam int NB = 4;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int L  = 1;

    logic          iClk12M = 1'b0;
    logic          iRsn;
    logic          iEnSample, iCoeffUpdateFlag, iClrOvr;
    logic [5:0]    iAddrRam;
    logic [15:0]   iWrDtRam;
    logic [6:0]    iNumOfCoeff;
    logic [3:0]    oCsnRam, oWrnRam;
    logic [15:0]   oAddrRam;
    logic [63:0]   oWrDtRam;
    logic          oEnDelay, oEnMul, oEnAcc, oEnAdd, oEnSum, oValid, oBusy, oOverrun;

    fir_mac_ctrl #(.NUM_BANK(NB), .ADDR_W(AW), .DATA_W(DW), .MAC_LAT(L)) dut (
        .iClk12M(iClk12M), .iRsn(iRsn), .iEnSample(iEnSample),
        .iCoeffUpdateFlag(iCoeffUpdateFlag), .iAddrRam(iAddrRam), .iWrDtRam(iWrDtRam),
        .iNumOfCoeff(iNumOfCoeff), .iClrOvr(iClrOvr), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam),
        .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam), .oEnDelay(oEnDelay), .oEnMul(oEnMul),
        .oEnAcc(oEnAcc), .oEnAdd(oEnAdd), .oEnSum(oEnSum), .oValid(oValid),
        .oBusy(oBusy), .oOverrun(oOverrun)
    );

    always #5 iClk12M = ~iClk12M;

    typedef struct {
        logic [3:0]  csn;
        logic [3:0]  wrn;
        logic [15:0] addr;
        logic [63:0] wd;
        logic [7:0]  fl;   // {delay, mul, acc, add, sum, valid, busy, ovr}
    } exp_t;

    typedef enum int {M_IDLE, M_WR, M_WREND, M_BUSY} mode_e;

    exp_t  sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    mode_e m_mode;
    int    m_t, m_ph;
    bit    m_ovr;

    function automatic int tb_taps(input int n);
        int t;
        t = n / 4 + ((n % 4) != 0 ? 1 : 0);
        if (t == 0) t = 1;
        if (t > 16) t = 16;
        return t;
    endfunction

    function automatic logic [15:0] rep(input int k);
        logic [3:0] kk;
        kk = 4'(k);
        return {4{kk}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_csn"},  64'(oCsnRam),  64'(e.csn));
        chk({tag, "_wrn"},  64'(oWrnRam),  64'(e.wrn));
        chk({tag, "_addr"}, 64'(oAddrRam), 64'(e.addr));
        chk({tag, "_wd"},   oWrDtRam,      e.wd);
        chk({tag, "_flags"},
            64'({oEnDelay, oEnMul, oEnAcc, oEnAdd, oEnSum, oValid, oBusy, oOverrun}),
            64'(e.fl));
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_t    = 1;
        m_ph   = 0;
        m_ovr  = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict outputs from the model, compare
    // at the falling edge, advance to just after the next rising edge.
    task automatic tick(input string tag, input bit s, input bit f, input int a,
                        input logic [15:0] d, input int n, input bit c);
        exp_t e;
        bit   set;
        int   bank, word;
        iEnSample = s; iCoeffUpdateFlag = f; iAddrRam = 6'(a);
        iWrDtRam = d; iNumOfCoeff = 7'(n); iClrOvr = c;
        e.csn = 4'hF; e.wrn = 4'h0; e.addr = 16'h0; e.wd = 64'h0; e.fl = 8'h0;
        e.fl[0] = m_ovr;
        set = 1'b0;
        case (m_mode)
            M_IDLE, M_WREND: begin
                e.fl[7] = s && !f;
                if (f) begin
                    m_mode = M_WR;
                    m_t    = tb_taps(n);
                    set    = s;
                end else if (s) begin
                    m_mode = M_BUSY;
                    m_ph   = 1;
                end
            end
            M_WR: begin
                bank   = a % 4;
                word   = a / 4;
                e.csn  = 4'hF & ~(4'b0001 << bank);
                e.wrn  = 4'b0001 << bank;
                e.addr = 16'(word) << (4 * bank);
                e.wd   = 64'(d) << (16 * bank);
                if (!f) m_mode = M_WREND;
            end
            M_BUSY: begin
                e.fl[1] = 1'b1;
                set     = s;
                if (m_ph <= m_t) begin
                    e.csn   = 4'h0;
                    e.addr  = rep(m_ph - 1);
                    e.fl[6] = 1'b1; e.fl[5] = 1'b1;
                    e.fl[4] = (m_ph == 1);
                end else begin
                    e.addr = rep(m_t - 1);
                    if (m_ph <= m_t + L) begin
                        e.fl[6] = 1'b1; e.fl[5] = 1'b1;
                    end else if (m_ph == m_t + L + 1) begin
                        e.fl[3] = 1'b1;
                    end else begin
                        e.fl[2] = 1'b1;
                        m_mode  = M_IDLE;
                    end
                end
                m_ph++;
            end
            default: ;
        endcase
        if (set)    m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        sb.push_back(e);
        @(negedge iClk12M);
        compare_outputs(tag);
        @(posedge iClk12M);
        #1;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 0, 0, 0, 16'h0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_csn"},  64'(oCsnRam),  64'hF);
        chk({tag, "_wrn"},  64'(oWrnRam),  64'h0);
        chk({tag, "_addr"}, 64'(oAddrRam), 64'h0);
        chk({tag, "_wd"},   oWrDtRam,      64'h0);
        chk({tag, "_flags"},
            64'({oEnDelay, oEnMul, oEnAcc, oEnAdd, oEnSum, oValid, oBusy, oOverrun}),
            64'h0);
    endtask

    initial begin
        iRsn = 1'b0; iEnSample = 1'b0; iCoeffUpdateFlag = 1'b0; iClrOvr = 1'b0;
        iAddrRam = '0; iWrDtRam = '0; iNumOfCoeff = '0;
        model_reset();
        @(negedge iClk12M);
        chk_reset_outputs("por");
        @(posedge iClk12M); #1;
        iRsn = 1'b1;
        idle_cycles("idle", 2);

        // Coefficient load: 16 words, word n -> bank n%4, address n/4, T=4.
        tick("wr_entry", 0, 1, 0, 16'h0, 16, 0);
        for (int n = 0; n < 16; n++)
            tick("wr", 0, (n != 15), n, 16'hA000 + 16'(n * 17), 16, 0);

        // Sweep T=4 from WREND, dropped strobe in LOOP cycle 3, then a
        // clear together with another dropped strobe, then a plain clear.
        tick("s4_strobe", 1, 0, 0, 16'h0, 0, 0);
        tick("s4_loop1", 0, 0, 0, 16'h0, 0, 0);
        tick("s4_loop2", 0, 0, 0, 16'h0, 0, 0);
        tick("s4_loop3", 1, 0, 0, 16'h0, 0, 0);
        tick("s4_loop4", 0, 0, 0, 16'h0, 0, 0);
        tick("s4_flush", 1, 0, 0, 16'h0, 0, 1);
        tick("s4_sum",   0, 0, 0, 16'h0, 0, 0);
        tick("s4_out",   0, 0, 0, 16'h0, 0, 0);
        tick("s4_clr",   0, 0, 0, 16'h0, 0, 1);
        idle_cycles("s4_after", 2);

        // iNumOfCoeff=0 clamps T to 1.
        tick("t1_entry", 0, 1, 0, 16'h0, 0, 0);
        tick("t1_wr",    0, 0, 22, 16'h5A5A, 0, 0);
        tick("t1_strobe", 1, 0, 0, 16'h0, 0, 0);
        idle_cycles("t1_run", 5);

        // Update and strobe together in WREND: update wins, overrun set, T=16.
        tick("cw_entry", 0, 1, 0, 16'h0, 0, 0);
        tick("cw_wr",    0, 0, 63, 16'hBEEF, 0, 0);
        tick("cw_both",  1, 1, 0, 16'h0, 63, 0);
        tick("cw_wr2",   0, 1, 41, 16'h1234, 63, 0);
        tick("cw_wr3",   0, 0, 6, 16'hC0DE, 63, 0);
        tick("cw_clr",   0, 0, 0, 16'h0, 0, 1);
        tick("t16_strobe", 1, 0, 0, 16'h0, 0, 0);
        idle_cycles("t16_run", 21);

        // Async reset in the middle of a T=16 sweep, then a T=1 sweep.
        tick("rst_strobe", 1, 0, 0, 16'h0, 0, 0);
        idle_cycles("rst_loop", 3);
        iRsn = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        model_reset();
        @(negedge iClk12M);
        chk_reset_outputs("rst_hold");
        @(posedge iClk12M); #1;
        iRsn = 1'b1;
        idle_cycles("rst_idle", 1);
        tick("rst_strobe2", 1, 0, 0, 16'h0, 0, 0);
        idle_cycles("rst_run", 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
